cdb_arbiter: RTL and testbench

- Shares the single-broadcast common data bus (CDB) between NUM_REQ functional-unit completion requesters in the R10K out-of-order core.
- Each requester owns a 1-entry holding buffer. A round-robin scheduler picks one buffered completion per cycle and drives the registered CDB outputs: tag and enable to the map table and RS, ROB index to the ROB complete port.
- Requesters see backpressure through per-requester ready. A squash input flushes all in-flight completions on mispredict recovery.

---
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single-broadcast common data bus between NUM_REQ functional-unit
//   completion requesters. Each requester owns a 1-entry holding buffer; a
//   round-robin scheduler picks one occupied buffer per cycle and drives the
//   registered CDB outputs (tag/enable to map table and RS, ROB index to ROB).
//
// Optional feature macro: CDB_ARB_BYPASS_EN
//   When defined, a requester with an empty buffer and req_valid=1 competes in
//   the same-cycle arbitration at its round-robin position; if it wins, it is
//   broadcast at the next edge without ever occupying its buffer.
//
// Ports:
//   clock        core clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   req_valid    per-requester completion valid
//   req_tag      packed per-requester destination physical tags
//   req_rob_idx  packed per-requester ROB indices
//   req_ready    per-requester accept (valid & ready = accepted this cycle)
//   squash       flush all buffered and in-flight completions
//   cdb_en       registered broadcast valid
//   cdb_tag      registered broadcast physical tag
//   cdb_rob_idx  registered ROB index to mark complete
//   pending_cnt  number of occupied holding buffers
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]        req_tag,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]    req_rob_idx,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            squash,
  output logic                            cdb_en,
  output logic [TAG_W-1:0]                cdb_tag,
  output logic [ROB_IDX_W-1:0]            cdb_rob_idx,
  output logic [$clog2(NUM_REQ+1)-1:0]    pending_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]   buf_valid_reg;
  logic [NUM_REQ-1:0]   buf_valid_next;
  logic [TAG_W-1:0]     buf_tag_reg [NUM_REQ];
  logic [ROB_IDX_W-1:0] buf_rob_reg [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic                 cdb_en_reg;
  logic [TAG_W-1:0]     cdb_tag_reg;
  logic [ROB_IDX_W-1:0] cdb_rob_reg;
  logic [CNT_W-1:0]     pending_cnt_reg;
  logic [CNT_W-1:0]     pending_cnt_next;

  logic [TAG_W-1:0]     in_tag [NUM_REQ];
  logic [ROB_IDX_W-1:0] in_rob [NUM_REQ];

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   accept;
  logic [NUM_REQ-1:0]   load;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [TAG_W-1:0]     win_tag;
  logic [ROB_IDX_W-1:0] win_rob;

  // Unpack the flat request buses into per-port views.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign in_tag[gi] = req_tag[gi*TAG_W +: TAG_W];
      assign in_rob[gi] = req_rob_idx[gi*ROB_IDX_W +: ROB_IDX_W];
    end
  endgenerate

`ifdef CDB_ARB_BYPASS_EN
  // An empty buffer with a live request competes directly.
  assign cand = buf_valid_reg | req_valid;
`else
  assign cand = buf_valid_reg;
`endif

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    grant     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!win_found && cand[sel]) begin
        win_found  = 1'b1;
        win_idx    = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  // Winner payload: the buffered entry always outranks the port's new input.
  always_comb begin
    win_tag = buf_tag_reg[win_idx];
    win_rob = buf_rob_reg[win_idx];
`ifdef CDB_ARB_BYPASS_EN
    if (!buf_valid_reg[win_idx]) begin
      win_tag = in_tag[win_idx];
      win_rob = in_rob[win_idx];
    end
`endif
  end

  assign req_ready = reset ? (~buf_valid_reg | grant) : '0;
  assign accept    = req_valid & req_ready;
  // A bypass winner (granted while its buffer is empty) is broadcast directly
  // and must not also be captured.
  assign load      = accept & ~(grant & ~buf_valid_reg);

  always_comb begin
    pending_cnt_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      buf_valid_next[i] = buf_valid_reg[i];
      if (squash)        buf_valid_next[i] = 1'b0;
      else if (load[i])  buf_valid_next[i] = 1'b1;
      else if (grant[i]) buf_valid_next[i] = 1'b0;
      pending_cnt_next = pending_cnt_next + CNT_W'(buf_valid_next[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_reg   <= '0;
      rr_ptr_reg      <= '0;
      cdb_en_reg      <= 1'b0;
      cdb_tag_reg     <= '0;
      cdb_rob_reg     <= '0;
      pending_cnt_reg <= '0;
    end else begin
      buf_valid_reg   <= buf_valid_next;
      pending_cnt_reg <= pending_cnt_next;
      cdb_en_reg      <= win_found & ~squash;
      // Squash kills the broadcast but leaves the rotation where it was.
      if (win_found && !squash) begin
        cdb_tag_reg <= win_tag;
        cdb_rob_reg <= win_rob;
        rr_ptr_reg  <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Per-buffer payload storage.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          buf_tag_reg[gi] <= '0;
          buf_rob_reg[gi] <= '0;
        end else if (load[gi]) begin
          buf_tag_reg[gi] <= in_tag[gi];
          buf_rob_reg[gi] <= in_rob[gi];
        end
      end
    end
  endgenerate

  assign cdb_en      = cdb_en_reg;
  assign cdb_tag     = cdb_tag_reg;
  assign cdb_rob_idx = cdb_rob_reg;
  assign pending_cnt = pending_cnt_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter. A reference model (per-port pending
//   slots plus a rotating priority origin) predicts each cycle's broadcast
//   and pushes it into a queue; a monitor on the falling edge pops and
//   compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int RW = 5;
  localparam int CW = $clog2(N + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*TW-1:0]   req_tag = '0;
  logic [N*RW-1:0]   req_rob_idx = '0;
  logic [N-1:0]      req_ready;
  logic              squash = 1'b0;
  logic              cdb_en;
  logic [TW-1:0]     cdb_tag;
  logic [RW-1:0]     cdb_rob_idx;
  logic [CW-1:0]     pending_cnt;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .ROB_IDX_W(RW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_rob_idx (req_rob_idx),
    .req_ready   (req_ready),
    .squash      (squash),
    .cdb_en      (cdb_en),
    .cdb_tag     (cdb_tag),
    .cdb_rob_idx (cdb_rob_idx),
    .pending_cnt (pending_cnt)
  );

  typedef struct {
    logic          en;
    logic [TW-1:0] tag;
    logic [RW-1:0] rob;
    int            cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            m_occ [N];
  logic [TW-1:0] m_tag [N];
  logic [RW-1:0] m_rob [N];
  int            m_rr;
  logic [TW-1:0] m_last_tag;
  logic [RW-1:0] m_last_rob;
  logic [N-1:0]  m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_occ[p] = 1'b0;
      m_tag[p] = '0;
      m_rob[p] = '0;
    end
    m_rr       = 0;
    m_last_tag = '0;
    m_last_rob = '0;
    m_ready    = '1;
  endtask

  // Predict the outcome of the coming posedge from current inputs and slots.
  task automatic model_step();
    int           win;
    int           best;
    int           d;
    int           cnt;
    bit           c;
    bit           acc;
    logic [N-1:0] rdy;
    exp_t         e;
    win  = -1;
    best = N;
    for (int p = 0; p < N; p++) begin
      c = m_occ[p];
`ifdef CDB_ARB_BYPASS_EN
      c = c | req_valid[p];
`endif
      d = (p - m_rr + N) % N;   // distance from the priority origin
      if (c && d < best) begin
        best = d;
        win  = p;
      end
    end
    for (int p = 0; p < N; p++) rdy[p] = !m_occ[p] || (win == p);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    m_ready = rdy;

    e.en = (win >= 0) && !squash;
    if (e.en) begin
      if (m_occ[win]) begin
        m_last_tag = m_tag[win];
        m_last_rob = m_rob[win];
      end else begin
        m_last_tag = req_tag[win*TW +: TW];
        m_last_rob = req_rob_idx[win*RW +: RW];
      end
      m_rr = (win + 1) % N;
    end
    e.tag = m_last_tag;
    e.rob = m_last_rob;

    cnt = 0;
    for (int p = 0; p < N; p++) begin
      acc = req_valid[p] && rdy[p];
      if (squash) m_occ[p] = 1'b0;
      else if (acc && !(win == p && !m_occ[p])) begin
        m_occ[p] = 1'b1;
        m_tag[p] = req_tag[p*TW +: TW];
        m_rob[p] = req_rob_idx[p*RW +: RW];
      end else if (win == p) m_occ[p] = 1'b0;
      if (m_occ[p]) cnt++;
    end
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                      input logic [N*RW-1:0] r, input logic sq);
    @(negedge clock);
    req_valid   = v;
    req_tag     = t;
    req_rob_idx = r;
    squash      = sq;
    #1;
    model_step();
  endtask

  function automatic logic [N*TW-1:0] pk_t(input int a, input int b, input int c, input int d);
    return {TW'(d), TW'(c), TW'(b), TW'(a)};
  endfunction

  function automatic logic [N*RW-1:0] pk_r(input int a, input int b, input int c, input int d);
    return {RW'(d), RW'(c), RW'(b), RW'(a)};
  endfunction

  // Monitor: one expected entry per clock edge the model has predicted.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cdb_en", 32'(cdb_en), 32'(mon_e.en));
      chk("cdb_tag", 32'(cdb_tag), 32'(mon_e.tag));
      chk("cdb_rob_idx", 32'(cdb_rob_idx), 32'(mon_e.rob));
      chk("pending_cnt", 32'(pending_cnt), 32'(mon_e.cnt));
      if (mon_e.en)
        $display("bcast tag=%0d rob=%0d pending=%0d", cdb_tag, cdb_rob_idx, pending_cnt);
    end
  end

  logic [N-1:0]    cur_v;
  logic [TW-1:0]   cur_t [N];
  logic [RW-1:0]   cur_r [N];
  logic [N*TW-1:0] rt;
  logic [N*RW-1:0] rr;

  initial begin
    model_reset();

    // Reset and idle.
    repeat (2) @(negedge clock);
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_cdb_en", 32'(cdb_en), 32'h0);
    chk("idle_pending", 32'(pending_cnt), 32'h0);
    chk("idle_ready", 32'(req_ready), 32'hF);

    // Single completion on port 1.
    step(4'b0010, pk_t(0, 12, 0, 0), pk_r(0, 3, 0, 0), 1'b0);
    repeat (4) step('0, '0, '0, 1'b0);

    // Round-robin with all ports loaded.
    repeat (14) step(4'b1111, pk_t(10, 11, 12, 13), pk_r(1, 2, 3, 4), 1'b0);
    repeat (5) step('0, '0, '0, 1'b0);

    // Backpressure with two active ports.
    repeat (10) step(4'b0011, pk_t(20, 21, 0, 0), pk_r(5, 6, 0, 0), 1'b0);
    repeat (4) step('0, '0, '0, 1'b0);

    // Squash with three buffers occupied and a new offer in the squash cycle.
    step(4'b0111, pk_t(40, 41, 42, 0), pk_r(8, 9, 10, 0), 1'b0);
    step(4'b1000, pk_t(0, 0, 0, 43), pk_r(0, 0, 0, 11), 1'b1);
    repeat (2) step('0, '0, '0, 1'b0);
    step(4'b0100, pk_t(0, 0, 44, 0), pk_r(0, 0, 12, 0), 1'b0);
    repeat (3) step('0, '0, '0, 1'b0);

    // Asynchronous reset mid-burst.
    repeat (5) step(4'b1111, pk_t(30, 31, 32, 33), pk_r(13, 14, 15, 16), 1'b0);
    #2;
    reset     = 1'b0;
    req_valid = '0;
    squash    = 1'b0;
    #1;
    chk("async_rst_cdb_en", 32'(cdb_en), 32'h0);
    chk("async_rst_pending", 32'(pending_cnt), 32'h0);
    chk("async_rst_ready", 32'(req_ready), 32'h0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) step(4'b1111, pk_t(50, 51, 52, 53), pk_r(17, 18, 19, 20), 1'b0);
    repeat (5) step('0, '0, '0, 1'b0);

    // Randomized traffic; a stalled requester keeps its payload stable.
    cur_v = '0;
    for (int p = 0; p < N; p++) begin
      cur_t[p] = '0;
      cur_r[p] = '0;
    end
    m_ready = '1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (!(cur_v[p] && !m_ready[p])) begin
          cur_v[p] = ($urandom_range(0, 99) < 55);
          cur_t[p] = TW'($urandom);
          cur_r[p] = RW'($urandom);
        end
        rt[p*TW +: TW] = cur_t[p];
        rr[p*RW +: RW] = cur_r[p];
      end
      step(cur_v, rt, rr, ($urandom_range(0, 19) == 0));
    end
    repeat (6) step('0, '0, '0, 1'b0);
    repeat (2) @(negedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
